// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  inst_req_i;
    logic [ADDR_WIDTH-1:0] inst_addr_i;
    logic                  inst_gnt_o;
    logic                  inst_rvalid_o;
    logic [DATA_WIDTH-1:0] inst_rdata_o;

    logic                  data_req_i;
    logic                  data_we_i;
    logic [3:0]            data_be_i;
    logic [ADDR_WIDTH-1:0] data_addr_i;
    logic [DATA_WIDTH-1:0] data_wdata_i;
    logic                  data_gnt_o;
    logic                  data_rvalid_o;
    logic [DATA_WIDTH-1:0] data_rdata_o;

    logic                  mem_ce_o;
    logic                  mem_we_o;
    logic [3:0]            mem_be_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    logic                  stall_if_o;
    logic                  stall_mem_o;

    modport slave (
        input  inst_req_i, inst_addr_i,
        output inst_gnt_o, inst_rvalid_o, inst_rdata_o,
        input  data_req_i, data_we_i, data_be_i,
        input  data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_ce_o, mem_we_o, mem_be_o,
        output mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output stall_if_o, stall_mem_o
    );

    modport master (
        output inst_req_i, inst_addr_i,
        input  inst_gnt_o, inst_rvalid_o, inst_rdata_o,
        output data_req_i, data_we_i, data_be_i,
        output data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_ce_o, mem_we_o, mem_be_o,
        input  mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  stall_if_o, stall_mem_o
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-ported fixed-latency memory.
// Data has priority; a saturating starve counter forces fetch progress.
module mem_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mem_arbiter_if.slave bus
);
    typedef enum logic { IDLE, BUSY } state_t;
    typedef enum logic { OWN_INST, OWN_DATA } owner_t;

    localparam logic [2:0] WAIT_C  = 3'(WAIT_CYCLES);
    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_t     r_state;
    owner_t     r_owner;
    logic       r_is_write;
    logic [2:0] r_cnt;
    logic [3:0] r_starve;

    logic w_resp;
    logic w_window;
    logic w_inst_win;
    logic w_gnt_i;
    logic w_gnt_d;
    logic w_rv_i;
    logic w_rv_d;

    assign w_resp     = (r_state == BUSY) && (r_cnt == WAIT_C);
    // Combinational grants must stay low while reset is held.
    assign w_window   = rst_i && ((r_state == IDLE) || w_resp);
    assign w_inst_win = bus.inst_req_i &&
                        (!bus.data_req_i || (r_starve == LIMIT_C));
    assign w_gnt_i    = w_window && w_inst_win;
    assign w_gnt_d    = w_window && bus.data_req_i && !w_inst_win;
    assign w_rv_i     = w_resp && (r_owner == OWN_INST);
    assign w_rv_d     = w_resp && (r_owner == OWN_DATA);

    always_comb begin
        bus.inst_gnt_o    = w_gnt_i;
        bus.data_gnt_o    = w_gnt_d;
        bus.inst_rvalid_o = w_rv_i;
        bus.data_rvalid_o = w_rv_d;
        bus.inst_rdata_o  = '0;
        bus.data_rdata_o  = '0;
        if (w_rv_i && !r_is_write)
            bus.inst_rdata_o = bus.mem_rdata_i;
        if (w_rv_d && !r_is_write)
            bus.data_rdata_o = bus.mem_rdata_i;

        bus.mem_ce_o    = w_gnt_i || w_gnt_d;
        bus.mem_we_o    = w_gnt_d && bus.data_we_i;
        bus.mem_be_o    = '0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (w_gnt_d) begin
            bus.mem_be_o    = bus.data_be_i;
            bus.mem_addr_o  = bus.data_addr_i;
            bus.mem_wdata_o = bus.data_wdata_i;
        end else if (w_gnt_i) begin
            bus.mem_be_o   = 4'hF;
            bus.mem_addr_o = bus.inst_addr_i;
        end

        bus.stall_if_o  = (rst_i && bus.inst_req_i && !w_gnt_i) ||
                          ((r_state == BUSY) && (r_owner == OWN_INST) && !w_rv_i);
        bus.stall_mem_o = (rst_i && bus.data_req_i && !w_gnt_d) ||
                          ((r_state == BUSY) && (r_owner == OWN_DATA) && !w_rv_d);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= IDLE;
            r_owner    <= OWN_INST;
            r_is_write <= 1'b0;
            r_cnt      <= '0;
            r_starve   <= '0;
        end else begin
            if (!bus.inst_req_i || w_gnt_i)
                r_starve <= '0;
            else if (w_gnt_d && (r_starve != 4'hF))
                r_starve <= r_starve + 4'd1;

            if (w_gnt_i || w_gnt_d) begin
                r_state    <= BUSY;
                r_cnt      <= 3'd1;
                r_owner    <= w_gnt_d ? OWN_DATA : OWN_INST;
                r_is_write <= w_gnt_d && bus.data_we_i;
            end else if (w_resp) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else if (r_state == BUSY) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: WAIT_CYCLES=2 instance for fetch/load/store/reset,
// WAIT_CYCLES=1 instance for back-to-back and starvation sequences.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst2 = 1'b0;
    logic rst1 = 1'b0;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b2 ();
    mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) b1 ();

    mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .WAIT_CYCLES(2), .STARVE_LIMIT(4)
    ) u_dut2 (
        .clk_i(clk), .rst_i(rst2), .bus(b2.slave)
    );

    mem_arbiter #(
        .ADDR_WIDTH(32), .DATA_WIDTH(32),
        .WAIT_CYCLES(1), .STARVE_LIMIT(4)
    ) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .bus(b1.slave)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int nwe;
        b2.inst_req_i   = 1'b1;
        b2.inst_addr_i  = 32'h100;
        b2.data_req_i   = 1'b1;
        b2.data_we_i    = 1'b0;
        b2.data_be_i    = 4'hF;
        b2.data_addr_i  = 32'h200;
        b2.data_wdata_i = 32'h0;
        b2.mem_rdata_i  = 32'hCAFE_0100;
        b1.inst_req_i   = 1'b0;
        b1.inst_addr_i  = 32'h500;
        b1.data_req_i   = 1'b0;
        b1.data_we_i    = 1'b0;
        b1.data_be_i    = 4'hF;
        b1.data_addr_i  = 32'h600;
        b1.data_wdata_i = 32'h0;
        b1.mem_rdata_i  = 32'h1234_5678;

        // Reset with requests pending: every output low
        @(negedge clk);
        check("rst_inst_gnt", b2.inst_gnt_o, 0);
        check("rst_data_gnt", b2.data_gnt_o, 0);
        check("rst_mem_ce", b2.mem_ce_o, 0);
        check("rst_mem_addr", b2.mem_addr_o, 0);
        check("rst_stall_if", b2.stall_if_o, 0);
        check("rst_stall_mem", b2.stall_mem_o, 0);
        check("rst_rvalid", b2.inst_rvalid_o, 0);
        tick;
        tick;

        // Lone fetch, granted in the first cycle out of reset
        rst2 = 1'b1;
        b2.data_req_i = 1'b0;
        @(negedge clk);
        check("f_gnt", b2.inst_gnt_o, 1);
        check("f_ce", b2.mem_ce_o, 1);
        check("f_addr", b2.mem_addr_o, 32'h100);
        check("f_be", b2.mem_be_o, 4'hF);
        check("f_we", b2.mem_we_o, 0);
        check("f_stall0", b2.stall_if_o, 0);
        tick;
        b2.inst_req_i = 1'b0;
        @(negedge clk);
        check("f_stall1", b2.stall_if_o, 1);
        check("f_rv1", b2.inst_rvalid_o, 0);
        check("f_ce1", b2.mem_ce_o, 0);
        tick;
        @(negedge clk);
        check("f_rv2", b2.inst_rvalid_o, 1);
        check("f_rdata2", b2.inst_rdata_o, 32'hCAFE_0100);
        check("f_stall2", b2.stall_if_o, 0);
        check("f_drdata2", b2.data_rdata_o, 0);
        tick;
        @(negedge clk);
        check("f_rv3", b2.inst_rvalid_o, 0);
        check("f_rdata3", b2.inst_rdata_o, 0);
        tick;

        // Simultaneous fetch and load
        b2.inst_req_i  = 1'b1;
        b2.inst_addr_i = 32'h104;
        b2.data_req_i  = 1'b1;
        b2.data_addr_i = 32'h200;
        @(negedge clk);
        check("s_dgnt0", b2.data_gnt_o, 1);
        check("s_ignt0", b2.inst_gnt_o, 0);
        check("s_addr0", b2.mem_addr_o, 32'h200);
        check("s_stif0", b2.stall_if_o, 1);
        check("s_stmem0", b2.stall_mem_o, 0);
        tick;
        b2.data_req_i = 1'b0;
        @(negedge clk);
        check("s_stif1", b2.stall_if_o, 1);
        check("s_stmem1", b2.stall_mem_o, 1);
        check("s_ce1", b2.mem_ce_o, 0);
        tick;
        @(negedge clk);
        check("s_drv2", b2.data_rvalid_o, 1);
        check("s_drdata2", b2.data_rdata_o, 32'hCAFE_0100);
        check("s_ignt2", b2.inst_gnt_o, 1);
        check("s_addr2", b2.mem_addr_o, 32'h104);
        check("s_irv2", b2.inst_rvalid_o, 0);
        check("s_stif2", b2.stall_if_o, 0);
        check("s_stmem2", b2.stall_mem_o, 0);
        tick;
        b2.inst_req_i = 1'b0;
        @(negedge clk);
        check("s_stif3", b2.stall_if_o, 1);
        tick;
        @(negedge clk);
        check("s_irv4", b2.inst_rvalid_o, 1);
        check("s_drv4", b2.data_rvalid_o, 0);
        tick;
        tick;

        // Store: one write strobe, zero read data on the acknowledge
        b2.data_req_i   = 1'b1;
        b2.data_we_i    = 1'b1;
        b2.data_be_i    = 4'b0011;
        b2.data_wdata_i = 32'hDEAD_BEEF;
        b2.data_addr_i  = 32'h40;
        nwe = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            nwe += int'(b2.mem_we_o);
            if (c == 0) begin
                check("w_gnt", b2.data_gnt_o, 1);
                check("w_be", b2.mem_be_o, 4'b0011);
                check("w_wdata", b2.mem_wdata_o, 32'hDEAD_BEEF);
                check("w_addr", b2.mem_addr_o, 32'h40);
            end
            if (c == 2) begin
                check("w_rv", b2.data_rvalid_o, 1);
                check("w_rdata", b2.data_rdata_o, 0);
            end
            tick;
            if (c == 0) begin
                b2.data_req_i = 1'b0;
                b2.data_we_i  = 1'b0;
                b2.data_be_i  = 4'hF;
            end
        end
        check("w_we_cycles", 64'(nwe), 1);

        // Reset in G+1 of a load abandons it
        b2.data_req_i  = 1'b1;
        b2.data_addr_i = 32'h300;
        @(negedge clk);
        check("r_gnt", b2.data_gnt_o, 1);
        tick;
        b2.data_req_i = 1'b0;
        rst2 = 1'b0;
        @(negedge clk);
        check("r_stmem", b2.stall_mem_o, 0);
        check("r_drv1", b2.data_rvalid_o, 0);
        check("r_ce", b2.mem_ce_o, 0);
        tick;
        @(negedge clk);
        check("r_drv2", b2.data_rvalid_o, 0);
        tick;
        rst2 = 1'b1;
        b2.data_req_i  = 1'b1;
        b2.data_addr_i = 32'h304;
        @(negedge clk);
        check("r_regnt", b2.data_gnt_o, 1);
        check("r_readdr", b2.mem_addr_o, 32'h304);
        tick;
        b2.data_req_i = 1'b0;
        @(negedge clk);
        check("r_rv_a", b2.data_rvalid_o, 0);
        tick;
        @(negedge clk);
        check("r_rv_b", b2.data_rvalid_o, 1);
        tick;

        // WAIT_CYCLES=1: back-to-back fetches
        rst1 = 1'b1;
        b1.inst_req_i = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("b_gnt%0d", c), b1.inst_gnt_o, 1);
            check($sformatf("b_rv%0d", c), b1.inst_rvalid_o,
                  (c >= 1) ? 1 : 0);
            tick;
        end
        b1.inst_req_i = 1'b0;
        @(negedge clk);
        check("b_rv_last", b1.inst_rvalid_o, 1);
        check("b_gnt_off", b1.inst_gnt_o, 0);
        tick;
        @(negedge clk);
        check("b_idle", b1.inst_rvalid_o, 0);
        tick;

        // Starvation: D,D,D,D,I repeating
        b1.inst_req_i = 1'b1;
        b1.data_req_i = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check($sformatf("st_i%0d", k), b1.inst_gnt_o,
                  (k % 5 == 4) ? 1 : 0);
            check($sformatf("st_d%0d", k), b1.data_gnt_o,
                  (k % 5 == 4) ? 0 : 1);
            tick;
        end
        b1.inst_req_i = 1'b0;
        b1.data_req_i = 1'b0;
        tick;
        tick;

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates a single-ported, fixed-latency memory between the instruction-fetch requester (pc/if stage) and the data requester (mem stage). One access is outstanding at a time, and back-to-back issue is supported. Data requests have priority, with an anti-starvation counter guaranteeing fetch progress. Per-requester stall outputs feed the hazard detection unit.

## Interface
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports
- WAIT_CYCLES, 2, memory read latency in cycles from issue to `mem_rdata_i` valid; legal range 1..7
- STARVE_LIMIT, 4, consecutive data grants tolerated while a fetch waits; legal range 1..15

Ports:
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset; asynchronous, active-low
- inst_req_i  in  1  fetch request; held with a stable address until granted
- inst_addr_i  in  ADDR_WIDTH  fetch address
- inst_gnt_o  out  1  fetch granted this cycle (combinational)
- inst_rvalid_o  out  1  fetch data valid
- inst_rdata_o  out  DATA_WIDTH  fetch data
- data_req_i  in  1  load/store request; held stable until granted
- data_we_i  in  1  1 = store
- data_be_i  in  4  byte enables
- data_addr_i  in  ADDR_WIDTH  data address
- data_wdata_i  in  DATA_WIDTH  store data
- data_gnt_o  out  1  data granted this cycle (combinational)
- data_rvalid_o  out  1  load data valid, or store acknowledge
- data_rdata_o  out  DATA_WIDTH  load data; 0 for a store
- mem_ce_o, mem_we_o  out  1  memory issue strobe, write strobe
- mem_be_o  out  4  memory byte enables
- mem_addr_o  out  ADDR_WIDTH  memory address
- mem_wdata_o  out  DATA_WIDTH  memory write data
- mem_rdata_i  in  DATA_WIDTH  memory read data, valid WAIT_CYCLES after issue
- stall_if_o, stall_mem_o  out  1  requester must hold (to HazardDetectionUnit)

## Operation
- States:
  - IDLE: no access outstanding.
  - BUSY: access outstanding. Registers `owner` (INST/DATA), `is_write`, and `cnt` (3 bits).
- Grant window: the cycle is a grant window when state = IDLE, or when state = BUSY and `cnt` = WAIT_CYCLES (the response cycle).
- Arbitration in a grant window:
  - DATA wins if `data_req_i` = 1, unless `inst_req_i` = 1 and `starve` = STARVE_LIMIT; then INST wins.
  - Otherwise INST wins if `inst_req_i` = 1.
- Grant cycle (issue):
  - Exactly one of `inst_gnt_o` / `data_gnt_o` = 1, and `mem_ce_o` = 1.
  - `mem_addr_o`, `mem_we_o`, `mem_be_o`, `mem_wdata_o` are muxed combinationally from the winner. INST drives we = 0 and be = 4'hF.
  - Next state: BUSY, `cnt` ← 1, owner and `is_write` latched.
- BUSY, `cnt` < WAIT_CYCLES: `cnt` increments; memory outputs are 0.
- Response cycle (`cnt` = WAIT_CYCLES):
  - The owner's rvalid = 1.
  - The owner's rdata = `mem_rdata_i`, or 0 when `is_write`.
  - A new grant is permitted in the same cycle. With no grant, next state is IDLE.
- `starve` (4-bit, saturating):
  - +1 on each DATA grant while `inst_req_i` = 1.
  - Cleared on an INST grant, and in any cycle with `inst_req_i` = 0.
- Stalls, for X in {inst, data}: `stall_X_o` = (X_req_i & ~X_gnt_o) | (BUSY & owner = X & ~X_rvalid_o).
- A requester may drop or change its request only after its grant. Requests are never cancelled once granted.
- Addresses pass through unchecked; alignment is the requester's responsibility.
- rdata outputs for the non-owner, and outside the response cycle, are 0.

## Timing
- Reset (`rst_i` = 0): state IDLE, `cnt` = 0, `starve` = 0. All outputs 0, including the gnt, stall, and mem_* outputs.
- Reset mid-access: the access is abandoned and no rvalid is produced. After release, the first grant can occur in the first cycle with `rst_i` = 1.
- Latency: an immediate grant in cycle G gives rvalid in cycle G+WAIT_CYCLES.
- Throughput: one access per WAIT_CYCLES cycles. WAIT_CYCLES = 1 gives one access per cycle, with the state staying in BUSY.
- Simultaneous requests in a grant window: exactly one grant. The loser's stall stays 1.
- `mem_we_o` is 1 only in a store's grant cycle. No memory strobes occur in non-grant cycles.

## Test plan
- Lone fetch: WAIT_CYCLES = 2, inst_req with addr 0x100 at cycle 0.
  - Required: inst_gnt = 1, mem_ce = 1, mem_addr = 0x100 at cycle 0.
  - Required: inst_rvalid = 1 with rdata = mem_rdata_i at cycle 2; stall_if = 1 in cycle 1 only.
- Simultaneous requests: inst and data load both requested at cycle 0.
  - Required: data granted at cycle 0, inst granted at cycle 2 in the same cycle as data_rvalid.
  - Required: stall_if = 1 in cycles 0–1.
- Store: data_we = 1, be = 4'b0011, wdata 0xDEADBEEF, addr 0x40.
  - Required: mem_we = 1 for exactly one cycle; data_rvalid at G+WAIT_CYCLES with rdata = 0.
- Starvation: STARVE_LIMIT = 4, WAIT_CYCLES = 1, data_req and inst_req held high continuously.
  - Required: grant sequence D,D,D,D,I,D,D,D,D,I…
- Reset mid-access: rst_i driven low in cycle G+1 of a load.
  - Required: all outputs 0 immediately; no rvalid after release; a new request is granted in the first cycle after release.
- Back-to-back with WAIT_CYCLES = 1: continuous inst_req.
  - Required: inst_gnt = 1 every cycle and inst_rvalid = 1 every cycle from cycle 1 on.
